mem_arbiter: RTL and testbench

Shares one `memory` instance between the core's instruction-fetch port and its load/store port. This is the step from the single-cycle core, which uses separate instruction and data memories, to a multi-cycle core with one unified memory. The block arbitrates per access, sequences a fixed-latency memory access with configurable wait states, and returns read data or a store acknowledge through a one-cycle response strobe. It sits between the core's fetch/LSU logic and the `memory` port (`we`, `addr`, `write_data`, `read_data`).

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter (FSM states, owner IDs).
// Build option MEM_ARB_RR_EN (consumed by arb_pick) selects round-robin arbitration.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam int CNT_W = 4;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational requester selection for mem_arbiter.
// MEM_ARB_RR_EN defined: alternate on contention; otherwise data wins over fetch.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output logic   pick_valid,
  output owner_t pick_owner
);

  assign pick_valid = if_req | d_req;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    pick_owner = OWN_DATA;
    if (if_req && d_req) begin
      pick_owner = (last_owner == OWN_DATA) ? OWN_FETCH : OWN_DATA;
    end else if (if_req) begin
      pick_owner = OWN_FETCH;
    end
  end
`else
  // History is irrelevant to fixed priority.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    pick_owner = d_req ? OWN_DATA : OWN_FETCH;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one combinational-read memory between fetch and load/store ports with
// WAIT_STATES extra access cycles; round-robin arbitration under MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

  arb_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  owner_t           owner, last_owner;
  logic             acc_we;
  logic [31:0]      acc_addr, acc_wdata;
  logic             err_flag;

  logic        pick_valid;
  owner_t      pick_owner;
  logic        grant, capture;
  logic        pick_we, pick_misaligned;
  logic [31:0] pick_addr, pick_wdata;

  arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );

  assign pick_addr       = (pick_owner == OWN_DATA) ? d_addr : if_addr;
  assign pick_we         = (pick_owner == OWN_DATA) && d_we;
  assign pick_wdata      = (pick_owner == OWN_DATA) ? d_wdata : 32'h0;
  assign pick_misaligned = is_misaligned(pick_addr[1:0]);
  assign capture         = (state == ARB_ACCESS) && (cnt == '0);

  // Grants are combinational, so they are held off while reset is asserted.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant      = 1'b0;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    unique case (state)
      ARB_IDLE, ARB_RESP: begin
        state_next = ARB_IDLE;
        if (rst_n && pick_valid) begin
          grant      = 1'b1;
          d_gnt      = (pick_owner == OWN_DATA);
          if_gnt     = (pick_owner == OWN_FETCH);
          cnt_next   = CNT_LOAD;
          state_next = pick_misaligned ? ARB_RESP : ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (cnt == '0) begin
          state_next = ARB_RESP;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_FETCH;
      last_owner <= OWN_FETCH;
      acc_we     <= 1'b0;
      acc_addr   <= '0;
      acc_wdata  <= '0;
      err_flag   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if (grant) begin
        owner      <= pick_owner;
        last_owner <= pick_owner;
        acc_we     <= pick_we;
        acc_addr   <= pick_addr;
        acc_wdata  <= pick_wdata;
        err_flag   <= pick_misaligned;
        if (pick_misaligned) begin
          if (pick_owner == OWN_DATA) d_rdata  <= '0;
          else                        if_rdata <= '0;
        end
      end
      if (capture) begin
        if (owner == OWN_DATA) d_rdata  <= acc_we ? 32'h0 : mem_rdata;
        else                   if_rdata <= mem_rdata;
      end
    end
  end

  assign if_rvalid = (state == ARB_RESP) && (owner == OWN_FETCH);
  assign d_rvalid  = (state == ARB_RESP) && (owner == OWN_DATA);
  assign rsp_err   = (state == ARB_RESP) && err_flag;
  assign mem_we    = capture && acc_we;
  assign mem_addr  = acc_addr;
  assign mem_wdata = acc_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (WAIT_STATES 0/2/3), each with a small
// word memory, driven by a vector table plus hand-written multi-cycle sequences.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;

  logic [2:0]       if_req, if_gnt, if_rvalid;
  logic [2:0][31:0] if_addr, if_rdata;
  logic [2:0]       d_req, d_we, d_gnt, d_rvalid;
  logic [2:0][31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]       rsp_err, mem_we;
  logic [2:0][31:0] mem_addr, mem_wdata, mem_rdata;

  logic        tb_wr;
  logic [5:0]  tb_widx;
  logic [31:0] tb_wdat;

  int passed;
  int total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic [31:0] mem [64];

    mem_arbiter #(.WAIT_STATES(gi == 0 ? 0 : (gi == 1 ? 2 : 3))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req[gi]),
      .if_addr   (if_addr[gi]),
      .if_gnt    (if_gnt[gi]),
      .if_rvalid (if_rvalid[gi]),
      .if_rdata  (if_rdata[gi]),
      .d_req     (d_req[gi]),
      .d_we      (d_we[gi]),
      .d_addr    (d_addr[gi]),
      .d_wdata   (d_wdata[gi]),
      .d_gnt     (d_gnt[gi]),
      .d_rvalid  (d_rvalid[gi]),
      .d_rdata   (d_rdata[gi]),
      .rsp_err   (rsp_err[gi]),
      .mem_we    (mem_we[gi]),
      .mem_addr  (mem_addr[gi]),
      .mem_wdata (mem_wdata[gi]),
      .mem_rdata (mem_rdata[gi])
    );

    assign mem_rdata[gi] = mem[mem_addr[gi][7:2]];

    always @(posedge clk) begin
      if (tb_wr) mem[tb_widx] <= tb_wdat;
      else if (mem_we[gi]) mem[mem_addr[gi][7:2]] <= mem_wdata[gi];
    end
  end

  typedef struct {
    bit          dside;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] dat);
    @(negedge clk);
    tb_wr = 1'b1; tb_widx = idx; tb_wdat = dat;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One request on instance k; lat = cycles from grant to rvalid (-1 if never).
  task automatic txn(input int k, input bit dside, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                     output bit err, output int we_cycles, output int addr_bad);
    int waited;
    lat = -1; rdata = '0; err = 1'b0; we_cycles = 0; addr_bad = 0;
    @(negedge clk);
    if (dside) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    #1;
    waited = 0;
    while (!(dside ? d_gnt[k] : if_gnt[k]) && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 20) begin
      d_req[k] = 1'b0; if_req[k] = 1'b0;
      return;
    end
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      d_req[k] = 1'b0; if_req[k] = 1'b0;
      #1;
      if (mem_we[k]) we_cycles++;
      if (dside ? d_rvalid[k] : if_rvalid[k]) begin
        lat   = c;
        rdata = dside ? d_rdata[k] : if_rdata[k];
        err   = rsp_err[k];
        break;
      end
      if (mem_addr[k] !== addr) addr_bad++;
    end
  endtask

  initial begin
    int          lat, we_cnt, addr_bad, ngr, first_c, last_c, both, rv_cnt, wr_cnt;
    logic [31:0] rdata;
    bit          err;
    logic [5:0]  pattern;
    logic [5:0]  exp_pattern;

    passed = 0; total = 0;
    rst_n = 1'b0;
    tb_wr = 1'b0; tb_widx = '0; tb_wdat = '0;
    if_req = '0; if_addr = '0; d_req = '0; d_we = '0; d_addr = '0; d_wdata = '0;

    vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
    vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'h00000000, 1'b0, 2, 1};
    vecs[2] = '{1'b0, 1'b0, 32'h20, 32'h0,        32'h12345678, 1'b0, 2, 0};
    vecs[3] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'h12345678, 1'b0, 2, 0};
    vecs[4] = '{1'b1, 1'b1, 32'h22, 32'hAAAA5555, 32'h00000000, 1'b1, 1, 0};
    vecs[5] = '{1'b0, 1'b0, 32'h13, 32'h0,        32'h00000000, 1'b1, 1, 0};
    vecs[6] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'h12345678, 1'b0, 2, 0};
    vecs[7] = '{1'b0, 1'b0, 32'h3C, 32'h0,        32'h600DC0DE, 1'b0, 2, 0};

    preload(6'd0,  32'h0BADF00D);
    preload(6'd4,  32'hDEADBEEF);
    preload(6'd8,  32'hFFFFFFFF);
    preload(6'd12, 32'h11111111);
    preload(6'd15, 32'h600DC0DE);
    preload(6'd16, 32'hCAFEF00D);

    // Reset state, with requests present to confirm grants stay low.
    @(negedge clk);
    if_req = 3'b111; d_req = 3'b111;
    #1;
    check("rst_gnt", 32'({if_gnt, d_gnt}), 32'h0);
    check("rst_flags", 32'({if_rvalid, d_rvalid, rsp_err, mem_we}), 32'h0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_mem_addr%0d", k), mem_addr[k], 32'h0);
      check($sformatf("rst_data%0d", k), if_rdata[k] | d_rdata[k] | mem_wdata[k], 32'h0);
    end
    if_req = '0; d_req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      txn(0, vecs[i].dside, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rdata, err, we_cnt, addr_bad);
      $display("vec %0d: %s we=%0d addr=%h rdata=%h err=%0d lat=%0d we_cycles=%0d",
               i, vecs[i].dside ? "D" : "F", vecs[i].we, vecs[i].addr, rdata, err, lat, we_cnt);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_we_cycles", i), we_cnt, vecs[i].exp_we);
      check($sformatf("v%0d_addr_hold", i), addr_bad, 0);
    end

    // Contention: both ports hold requests for six grants.
    reset_pulse();
    @(negedge clk);
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h10;
    if_req[0] = 1'b1; if_addr[0] = 32'h20;
    pattern = '0; ngr = 0; first_c = -1; last_c = -1; both = 0;
    for (int c = 0; c < 40 && ngr < 6; c++) begin
      #1;
      if (d_gnt[0] && if_gnt[0]) both++;
      if (d_gnt[0] || if_gnt[0]) begin
        pattern = {pattern[4:0], d_gnt[0]};
        if (ngr == 0) first_c = c;
        last_c = c;
        ngr++;
      end
      @(negedge clk);
    end
    d_req[0] = 1'b0; if_req[0] = 1'b0;
    repeat (3) @(negedge clk);
`ifdef MEM_ARB_RR_EN
    exp_pattern = 6'b101010;
`else
    exp_pattern = 6'b111111;
`endif
    $display("contention: grants=%0d pattern=%b span=%0d", ngr, pattern, last_c - first_c);
    check("arb_count", ngr, 6);
    check("arb_pattern", 32'(pattern), 32'(exp_pattern));
    check("arb_span", last_c - first_c, 10);
    check("arb_double_gnt", both, 0);

    // WAIT_STATES=3 load.
    txn(2, 1'b1, 1'b0, 32'h40, 32'h0, lat, rdata, err, we_cnt, addr_bad);
    $display("ws3 load: rdata=%h err=%0d lat=%0d addr_bad=%0d", rdata, err, lat, addr_bad);
    check("ws3_lat", lat, 5);
    check("ws3_rdata", rdata, 32'hCAFEF00D);
    check("ws3_err", 32'(err), 32'h0);
    check("ws3_addr_hold", addr_bad, 0);
    repeat (2) @(negedge clk);
    #1;
    check("ws3_addr_idle", mem_addr[2], 32'h40);

    // Reset during ACCESS of a WAIT_STATES=2 store.
    @(negedge clk);
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h30; d_wdata[1] = 32'h99999999;
    #1;
    check("rsta_gnt", 32'(d_gnt[1]), 32'h1);
    @(negedge clk);
    d_req[1] = 1'b0;
    #1;
    check("rsta_access_addr", mem_addr[1], 32'h30);
    #2;
    rst_n = 1'b0;
    #1;
    check("rsta_async_flags", 32'({if_gnt[1], if_rvalid[1], d_gnt[1], d_rvalid[1], rsp_err[1], mem_we[1]}), 32'h0);
    check("rsta_async_addr", mem_addr[1], 32'h0);
    check("rsta_async_wdata", mem_wdata[1], 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rv_cnt = 0; wr_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (d_rvalid[1]) rv_cnt++;
      if (mem_we[1]) wr_cnt++;
    end
    check("rsta_no_rvalid", rv_cnt, 0);
    check("rsta_no_write", wr_cnt, 0);
    txn(1, 1'b1, 1'b0, 32'h30, 32'h0, lat, rdata, err, we_cnt, addr_bad);
    $display("ws2 readback: rdata=%h lat=%0d", rdata, lat);
    check("rsta_word", rdata, 32'h11111111);
    check("rsta_ws2_lat", lat, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got %0d checks expected completion", total);
    $fatal(1);
  end

endmodule
